board_move_engine: RTL and testbench

//  2048 game-state stage directly upstream of the grid drawer: holds the 4x4 board and drives `values`.

---
 rtl/game2048_pkg.sv | 38 +++
 rtl/line_merge.sv | 44 ++++
 rtl/board_move_engine.sv | 222 ++++++++++++++++++++++
 tb/tb_board_move_engine.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/game2048_pkg.sv
// Shared types and helpers for the 2048 board engine: board geometry, move
// direction codes, FSM states and the line-to-cell index mapping.
package game2048_pkg;

    localparam int CELL_W  = 4;
    localparam int NCELLS  = 16;
    localparam int BOARD_W = 64;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_SLIDE  = 3'd2,
        S_SPAWN  = 3'd3,
        S_CHECK  = 3'd4,
        S_COMMIT = 3'd5
    } state_t;

    // Position 0 of every line sits on the edge the tiles slide toward.
    function automatic logic [3:0] line_cell_index(input logic [1:0] dir,
                                                   input logic [1:0] line,
                                                   input logic [1:0] pos);
        logic [3:0] idx;
        case (dir)
            DIR_UP:    idx = {pos, line};
            DIR_DOWN:  idx = {2'd3 - pos, line};
            DIR_LEFT:  idx = {line, pos};
            DIR_RIGHT: idx = {line, 2'd3 - pos};
            default:   idx = {line, pos};
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/line_merge.sv
// Combinational 2048 line operation: compact non-zero cells toward position 0,
// then merge equal neighbours once each, scanning from position 0.
module line_merge
    import game2048_pkg::*;
(
    input  logic [3:0][CELL_W-1:0] i_line,
    output logic [3:0][CELL_W-1:0] o_line,
    output logic                   o_line_changed
);

    logic [4:0][CELL_W-1:0] w_comp;

    // Compaction writes every cell at the next free slot; a zero simply gets
    // overwritten by the next non-zero. Slot 4 stays zero as the merge sentinel.
    always_comb begin : compact_merge
        logic [1:0] k;
        logic       skip;
        w_comp = {(5 * CELL_W){1'b0}};
        k      = 2'd0;
        for (int i = 0; i < 4; i++) begin
            w_comp[{1'b0, k}] = i_line[i];
            k = k + {1'b0, (i_line[i] != 4'd0)};
        end
        o_line = {(4 * CELL_W){1'b0}};
        k      = 2'd0;
        skip   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (skip) begin
                skip = 1'b0;
            end else if ((w_comp[i] != 4'd0) && (w_comp[i] == w_comp[i+1]) &&
                         (w_comp[i] != 4'd15)) begin
                o_line[k] = w_comp[i] + 4'd1;
                k         = k + 2'd1;
                skip      = 1'b1;
            end else begin
                o_line[k] = w_comp[i];
                k         = k + 2'd1;
            end
        end
    end

    assign o_line_changed = (o_line != i_line);

endmodule

// File: rtl/board_move_engine.sv
// 2048 game-state engine: holds the committed board, applies moves on a working
// copy, spawns tiles from an LFSR and maintains the sticky won/over flags.
module board_move_engine
    import game2048_pkg::*;
#(
    parameter logic [3:0] WIN_EXP   = 4'd11,
    parameter logic [7:0] LFSR_SEED = 8'hA5
)(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               move_valid,
    input  logic [1:0]         move_dir,
    output logic               move_ready,
    input  logic               load_valid,
    input  logic [BOARD_W-1:0] load_values,
    output logic [BOARD_W-1:0] values,
    output logic               busy,
    output logic               done,
    output logic               changed,
    output logic               game_won,
    output logic               game_over
);

    state_t                r_state;
    state_t                w_next_state;
    logic [CELL_W-1:0]     r_work [NCELLS];
    logic [7:0]            r_lfsr;
    logic [1:0]            r_dir;
    logic [1:0]            r_line;
    logic [3:0]            r_idx;
    logic [3:0]            r_scan;
    logic                  r_first;
    logic                  r_spawn_more;
    logic                  r_changed;
    logic [BOARD_W-1:0]    r_values;
    logic                  r_done;
    logic                  r_changed_o;
    logic                  r_won;
    logic                  r_over;

    logic [3:0]            w_cell_idx [4];
    logic [3:0][CELL_W-1:0] w_line_in;
    logic [3:0][CELL_W-1:0] w_line_out;
    logic                  w_line_changed;
    logic [3:0]            w_spawn_idx;
    logic                  w_spawn_empty;
    logic                  w_spawn_exit;
    logic                  w_win;
    logic                  w_over;
    logic                  w_ready;
    logic                  w_fb;

    assign w_ready       = (r_state == S_IDLE) && !r_over;
    assign w_fb          = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_spawn_idx   = r_first ? r_lfsr[3:0] : r_idx;
    assign w_spawn_empty = (r_work[w_spawn_idx] == 4'd0);
    assign w_spawn_exit  = w_spawn_empty || (r_scan == 4'd15);

    assign move_ready = w_ready;
    assign busy       = (r_state != S_IDLE);
    assign values     = r_values;
    assign done       = r_done;
    assign changed    = r_changed_o;
    assign game_won   = r_won;
    assign game_over  = r_over;

    // Gather the line currently being slid from the working board.
    always_comb begin
        for (int p = 0; p < 4; p++) begin
            w_cell_idx[p] = line_cell_index(r_dir, r_line, 2'(p));
            w_line_in[p]  = r_work[w_cell_idx[p]];
        end
    end

    line_merge u_line_merge (
        .i_line         (w_line_in),
        .o_line         (w_line_out),
        .o_line_changed (w_line_changed)
    );

    // Win and game-over evaluation on the working board.
    always_comb begin : board_eval
        logic any_empty;
        logic any_pair;
        w_win     = 1'b0;
        any_empty = 1'b0;
        any_pair  = 1'b0;
        for (int i = 0; i < NCELLS; i++) begin
            w_win     = w_win | (r_work[i] >= WIN_EXP);
            any_empty = any_empty | (r_work[i] == 4'd0);
        end
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 3; b++) begin
                any_pair = any_pair | (r_work[a*4+b] == r_work[a*4+b+1]);
                any_pair = any_pair | (r_work[b*4+a] == r_work[b*4+a+4]);
            end
        end
        w_over = !any_empty && !any_pair;
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_INIT: w_next_state = S_SPAWN;
            S_IDLE: begin
                if (load_valid) begin
                    w_next_state = S_CHECK;
                end else if (move_valid && w_ready) begin
                    w_next_state = S_SLIDE;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_SLIDE: begin
                if (r_line == 2'd3) begin
                    w_next_state = (r_changed || w_line_changed) ? S_SPAWN : S_CHECK;
                end else begin
                    w_next_state = S_SLIDE;
                end
            end
            S_SPAWN: begin
                if (w_spawn_exit && !r_spawn_more) begin
                    w_next_state = S_CHECK;
                end else begin
                    w_next_state = S_SPAWN;
                end
            end
            S_CHECK:  w_next_state = S_COMMIT;
            S_COMMIT: w_next_state = S_IDLE;
            default:  w_next_state = S_INIT;
        endcase
    end

    // Working board, LFSR, spawn scan and committed outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NCELLS; i++) r_work[i] <= 4'd0;
            r_lfsr       <= LFSR_SEED;
            r_dir        <= 2'd0;
            r_line       <= 2'd0;
            r_idx        <= 4'd0;
            r_scan       <= 4'd0;
            r_first      <= 1'b1;
            r_spawn_more <= 1'b0;
            r_changed    <= 1'b0;
            r_values     <= {BOARD_W{1'b0}};
            r_done       <= 1'b0;
            r_changed_o  <= 1'b0;
            r_won        <= 1'b0;
            r_over       <= 1'b0;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
            r_done <= 1'b0;
            case (r_state)
                S_INIT: begin
                    for (int i = 0; i < NCELLS; i++) r_work[i] <= 4'd0;
                    r_changed    <= 1'b0;
                    r_first      <= 1'b1;
                    r_scan       <= 4'd0;
                    r_spawn_more <= 1'b1;
                end
                S_IDLE: begin
                    if (load_valid) begin
                        for (int i = 0; i < NCELLS; i++) r_work[i] <= load_values[4*i +: 4];
                        r_changed <= 1'b0;
                        r_won     <= 1'b0;
                        r_over    <= 1'b0;
                    end else if (move_valid && w_ready) begin
                        r_dir        <= move_dir;
                        r_line       <= 2'd0;
                        r_changed    <= 1'b0;
                        r_first      <= 1'b1;
                        r_scan       <= 4'd0;
                        r_spawn_more <= 1'b0;
                    end
                end
                S_SLIDE: begin
                    for (int p = 0; p < 4; p++) r_work[w_cell_idx[p]] <= w_line_out[p];
                    r_line    <= r_line + 2'd1;
                    r_changed <= r_changed | w_line_changed;
                end
                S_SPAWN: begin
                    if (w_spawn_empty) begin
                        r_work[w_spawn_idx] <= (r_lfsr[7:5] == 3'd0) ? 4'd2 : 4'd1;
                    end
                    if (w_spawn_exit) begin
                        r_first      <= 1'b1;
                        r_scan       <= 4'd0;
                        r_spawn_more <= 1'b0;
                    end else begin
                        r_first <= 1'b0;
                        r_idx   <= w_spawn_idx + 4'd1;
                        r_scan  <= r_scan + 4'd1;
                    end
                end
                S_CHECK: begin
                    r_won  <= r_won | w_win;
                    r_over <= r_over | w_over;
                end
                S_COMMIT: begin
                    for (int i = 0; i < NCELLS; i++) r_values[4*i +: 4] <= r_work[i];
                    r_done      <= 1'b1;
                    r_changed_o <= r_changed;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_move_engine.sv
// Directed bench for board_move_engine: expectations are queued when stimulus
// is driven and compared against the board committed with each done pulse.
module tb_board_move_engine;
    import game2048_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        move_valid;
    logic [1:0]  move_dir;
    logic        move_ready;
    logic        load_valid;
    logic [63:0] load_values;
    logic [63:0] values;
    logic        busy;
    logic        done;
    logic        changed;
    logic        game_won;
    logic        game_over;

    always #5 clock = ~clock;

    board_move_engine dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .move_valid  (move_valid),
        .move_dir    (move_dir),
        .move_ready  (move_ready),
        .load_valid  (load_valid),
        .load_values (load_values),
        .values      (values),
        .busy        (busy),
        .done        (done),
        .changed     (changed),
        .game_won    (game_won),
        .game_over   (game_over)
    );

    // kind: 0 exact board, 1 base board plus one spawned tile, 2 fresh game
    typedef struct {
        string       tag;
        int          kind;
        logic [63:0] board;
        logic        chg;
        logic        won;
        logic        over;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int count_nz(input logic [63:0] b);
        int n = 0;
        for (int i = 0; i < 16; i++) if (b[4*i +: 4] != 4'd0) n++;
        return n;
    endfunction

    function automatic logic spawn_ok(input logic [63:0] obs, input logic [63:0] base);
        int   diffs = 0;
        logic ok    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (obs[4*i +: 4] !== base[4*i +: 4]) begin
                diffs++;
                if (base[4*i +: 4] != 4'd0) ok = 1'b0;
                if (obs[4*i +: 4] != 4'd1 && obs[4*i +: 4] != 4'd2) ok = 1'b0;
            end
        end
        return ok && (diffs == 1);
    endfunction

    function automatic logic init_ok(input logic [63:0] obs);
        logic ok = (count_nz(obs) == 2);
        for (int i = 0; i < 16; i++) if (obs[4*i +: 4] > 4'd2) ok = 1'b0;
        return ok;
    endfunction

    task automatic wait_commit(output int lat);
        exp_t e;
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clock); #1;
            lat++;
        end
        chk("done_seen", done, 1'b1);
        if (sb.size() == 0) begin
            chk("sb_has_entry", 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            case (e.kind)
                0:       chk({e.tag, "_board"}, values, e.board);
                1:       chk({e.tag, "_spawn"}, spawn_ok(values, e.board), 1'b1);
                default: chk({e.tag, "_init"}, init_ok(values), 1'b1);
            endcase
            chk({e.tag, "_changed"}, changed, e.chg);
            chk({e.tag, "_won"}, game_won, e.won);
            chk({e.tag, "_over"}, game_over, e.over);
            @(posedge clock); #1;
            chk({e.tag, "_done_pulse"}, done, 1'b0);
        end
    endtask

    task automatic do_load(input string tag, input logic [63:0] b, input logic won, input logic over);
        int lat;
        sb.push_back('{tag: tag, kind: 0, board: b, chg: 1'b0, won: won, over: over});
        load_valid  = 1'b1;
        load_values = b;
        @(posedge clock); #1;
        load_valid = 1'b0;
        wait_commit(lat);
    endtask

    task automatic do_move(input string tag, input logic [1:0] dir, input int kind,
                           input logic [63:0] b, input logic chg, input logic won,
                           input logic over, output int lat);
        chk({tag, "_ready"}, move_ready, 1'b1);
        sb.push_back('{tag: tag, kind: kind, board: b, chg: chg, won: won, over: over});
        move_valid = 1'b1;
        move_dir   = dir;
        @(posedge clock); #1;
        move_valid = 1'b0;
        wait_commit(lat);
    endtask

    task automatic reset_and_init(input string tag);
        int lat;
        reset_n = 1'b0;
        @(posedge clock); #1;
        chk({tag, "_rst_values"}, values, 64'd0);
        chk({tag, "_rst_done"}, done, 1'b0);
        chk({tag, "_rst_changed"}, changed, 1'b0);
        chk({tag, "_rst_won"}, game_won, 1'b0);
        chk({tag, "_rst_over"}, game_over, 1'b0);
        reset_n = 1'b1;
        sb.push_back('{tag: tag, kind: 2, board: 64'd0, chg: 1'b0, won: 1'b0, over: 1'b0});
        wait_commit(lat);
        chk({tag, "_ready"}, move_ready, 1'b1);
    endtask

    initial begin
        int   lat;
        logic seen_done;
        reset_n     = 1'b0;
        move_valid  = 1'b0;
        move_dir    = 2'd0;
        load_valid  = 1'b0;
        load_values = 64'd0;

        reset_and_init("init");

        do_load("t2_load", 64'h0000_0000_0000_2211, 1'b0, 1'b0);
        do_move("t2_left", DIR_LEFT, 1, 64'h0000_0000_0000_0032, 1'b1, 1'b0, 1'b0, lat);

        do_load("t3_load_row", 64'h0000_0000_0000_1111, 1'b0, 1'b0);
        do_move("t3_right", DIR_RIGHT, 1, 64'h0000_0000_0000_2200, 1'b1, 1'b0, 1'b0, lat);
        do_load("t3_load_col", 64'h0003_0001_0000_0001, 1'b0, 1'b0);
        do_move("t3_up", DIR_UP, 1, 64'h0000_0000_0003_0002, 1'b1, 1'b0, 1'b0, lat);

        do_load("t4_load", 64'h0000_0000_0000_4321, 1'b0, 1'b0);
        do_move("t4_left", DIR_LEFT, 0, 64'h0000_0000_0000_4321, 1'b0, 1'b0, 1'b0, lat);
        chk("t4_latency", 64'(lat), 64'd6);

        do_load("t5_checker", 64'h1212_2121_1212_2121, 1'b0, 1'b1);
        chk("t5_not_ready", move_ready, 1'b0);
        seen_done  = 1'b0;
        move_valid = 1'b1;
        move_dir   = DIR_LEFT;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock); #1;
            seen_done = seen_done | done;
        end
        move_valid = 1'b0;
        chk("t5_move_ignored", seen_done, 1'b0);
        chk("t5_board_kept", values, 64'h1212_2121_1212_2121);
        chk("t5_idle", busy, 1'b0);
        reset_and_init("t5_reinit");

        do_load("t6_load_10", 64'h0000_0000_0000_00AA, 1'b0, 1'b0);
        do_move("t6_merge_win", DIR_LEFT, 1, 64'h0000_0000_0000_000B, 1'b1, 1'b1, 1'b0, lat);
        do_load("t6_load_15", 64'h0000_0000_0000_00FF, 1'b1, 1'b0);
        do_move("t6_saturate", DIR_LEFT, 0, 64'h0000_0000_0000_00FF, 1'b0, 1'b1, 1'b0, lat);

        chk("t6_abort_ready", move_ready, 1'b1);
        move_valid = 1'b1;
        move_dir   = DIR_RIGHT;
        @(posedge clock); #1;
        move_valid = 1'b0;
        @(posedge clock); #1;
        chk("t6_abort_busy", busy, 1'b1);
        reset_and_init("t6_abort");

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
